// File: rtl/fetch_seq_if.sv
// Bus bundle between the fetch sequencer and its controller/decoder.
// Optional retired counter port exists only when FETCH_RETIRE_CNT_EN is defined.
interface fetch_seq_if #(
    parameter int PC_W = 16
);
    // start is a one-cycle request qualified by the sequencer's own state
    // (honoured in IDLE/HALTED only); there is no ready back-pressure.
    logic            start;
    logic [PC_W-1:0] start_addr;
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] jmp_loc;
    logic            halt;
    logic [PC_W-1:0] pc;
    logic            running;
    logic            done;
    logic [1:0]      dbg_state;
`ifdef FETCH_RETIRE_CNT_EN
    logic [15:0]     retired;
`endif

    modport master (
        output start, start_addr, stall, branch_taken, jmp_loc, halt,
        input  pc, running, done, dbg_state
`ifdef FETCH_RETIRE_CNT_EN
        , input retired
`endif
    );

    modport slave (
        input  start, start_addr, stall, branch_taken, jmp_loc, halt,
        output pc, running, done, dbg_state
`ifdef FETCH_RETIRE_CNT_EN
        , output retired
`endif
    );
endinterface

// File: rtl/fetch_seq.sv
// Program-counter sequencer: IDLE -> RUN -> HALTED with stall/halt/branch priority.
// Define FETCH_RETIRE_CNT_EN to add the saturating 16-bit retired counter.
module fetch_seq #(
    parameter int PC_W     = 16,
    parameter int RESET_PC = 0
) (
    input logic          clk,
    input logic          reset_n,
    fetch_seq_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic            running_q;
    logic            done_q;
`ifdef FETCH_RETIRE_CNT_EN
    logic [15:0]     retired_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            pc_q      <= PC_W'(RESET_PC);
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef FETCH_RETIRE_CNT_EN
            retired_q <= 16'd0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, HALTED: begin
                    if (bus.start) begin
                        pc_q      <= bus.start_addr;
                        state     <= RUN;
                        running_q <= 1'b1;
`ifdef FETCH_RETIRE_CNT_EN
                        retired_q <= 16'd0;
`endif
                    end
                end
                RUN: begin
                    // stall freezes everything, including a pending halt or branch
                    if (!bus.stall) begin
                        if (bus.halt) begin
                            state     <= HALTED;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            if (bus.branch_taken) pc_q <= bus.jmp_loc;
                            else                  pc_q <= pc_q + 1'b1;
`ifdef FETCH_RETIRE_CNT_EN
                            if (retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
`endif
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state;
`ifdef FETCH_RETIRE_CNT_EN
    assign bus.retired   = retired_q;
`endif
endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter PC_W, default 16: program counter width; matches instruction ROM pc input.
REQ-002 Parameter RESET_PC, default 0: pc value loaded on reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 start  input  1  single-cycle request to begin execution at start_addr.
REQ-006 start_addr  input  PC_W  first instruction address, sampled with start.
REQ-007 stall  input  1  hold current pc; no advance, no branch, no halt accepted.
REQ-008 branch_taken  input  1  execute stage resolved a taken branch or jump this cycle.
REQ-009 jmp_loc  input  PC_W  branch/jump target from instruction decode, valid with branch_taken.
REQ-010 halt  input  1  decoded HALT opcode (4'b1110) at current pc.
REQ-011 pc  output  PC_W  address presented to instruction ROM; registered.
REQ-012 running  output  1  high while in RUN state.
REQ-013 done  output  1  one-cycle pulse on entry to HALTED.

Function
REQ-014 Three states: IDLE, RUN, HALTED; encoding is free.
REQ-015 IDLE: pc holds; start=1 -> pc <= start_addr, next state RUN.
REQ-016 RUN, stall=0, halt=0, branch_taken=0: pc <= pc + 1 each cycle.
REQ-017 RUN, stall=0, halt=0, branch_taken=1: pc <= jmp_loc; no increment that cycle.
REQ-018 RUN, stall=0, halt=1: pc holds; next state HALTED; done=1 in the following cycle only.
REQ-019 Priority: stall > halt > branch_taken > increment.
REQ-020 Increment wraps modulo 2^PC_W: pc = all-ones -> 0; no flag raised.
REQ-021 start ignored in RUN; start in HALTED behaves as in IDLE (restart at start_addr).
REQ-022 branch_taken, halt, and stall ignored in IDLE and HALTED.
REQ-023 Latency: pc change visible one clk after the qualifying input cycle; no combinational path from any input to pc.
REQ-024 running = (state == RUN), registered.
REQ-025 done deasserts after exactly one cycle even if the bench holds halt high.

Reset
REQ-026 reset_n=0 at a rising edge -> state IDLE, pc=RESET_PC, running=0, done=0, counter (if present) = 0.
REQ-027 Reset takes precedence over all other inputs, including mid-RUN and on the same cycle as start.
REQ-028 No asynchronous reset path.

Configuration
REQ-029 Macro FETCH_RETIRE_CNT_EN: when defined, adds output retired (16 bits); increments by 1 on each RUN cycle with stall=0 and halt=0; saturates at 16'hFFFF; clears on reset or an accepted start.
REQ-030 When FETCH_RETIRE_CNT_EN is undefined, the retired port and counter logic are absent; all other behaviour is identical.

Verification
REQ-031 Reset, then start=1 with start_addr=50 -> pc=50, running=1 next cycle; pc=51,52,53 on the next three cycles.
REQ-032 In RUN at pc=60, branch_taken=1 with jmp_loc=10 -> pc=10 next cycle, then 11.
REQ-033 At pc=70: stall=1 for 3 cycles, with branch_taken=1 and halt=1 also asserted -> pc stays 70 and state stays RUN; after stall drops, pc=71.
REQ-034 At pc=134: halt=1 and branch_taken=1 together -> pc stays 134, done pulses once, running=0; start with start_addr=0 -> RUN at pc=0.
REQ-035 start_addr=16'hFFFE -> pc sequence FFFE, FFFF, 0000; with FETCH_RETIRE_CNT_EN defined, retired=3 after three unstalled cycles.
REQ-036 reset_n=0 at pc=80 in RUN -> next cycle pc=RESET_PC, state IDLE, done=0; a start in the same cycle as reset is ignored.
